// File: rtl/matrix_calc_pkg.sv
// Shared limits, widths and state encoding for the matrix display reader.
package matrix_calc_pkg;

    localparam int MAX_MATRICES = 10;
    localparam int MAX_DIM      = 5;
    localparam int META_TIMEOUT = 4;

    localparam int ID_W   = 4;
    localparam int DIM_W  = 3;
    localparam int DATA_W = 8;
    localparam int TMO_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_META,
        READ,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    // A request is serviceable only when the slot exists and both dimensions are 1..MAX_DIM.
    function automatic logic req_ok(input logic [ID_W-1:0]  id,
                                    input logic [DIM_W-1:0] m,
                                    input logic [DIM_W-1:0] n);
        return (id <= ID_W'(MAX_MATRICES - 1)) &&
               (m != '0) && (m <= DIM_W'(MAX_DIM)) &&
               (n != '0) && (n <= DIM_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row-major row/column stepper with wrap at n-1 and last-element detection.
module matrix_rc_counter
    import matrix_calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [DIM_W-1:0] i_m,
    input  logic [DIM_W-1:0] i_n,
    output logic [DIM_W-1:0] o_row,
    output logic [DIM_W-1:0] o_col,
    output logic             o_last
);

    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic             w_col_wrap;

    assign w_col_wrap = (r_col == (i_n - 1'b1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == (i_m - 1'b1)) && w_col_wrap;

endmodule

// File: rtl/matrix_display_reader.sv
// Streams a stored matrix element by element: one storage fetch per element,
// each presented on a valid/ready handshake before the next fetch is issued.
module matrix_display_reader
    import matrix_calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ID_W-1:0]   disp_id,
    input  logic [DIM_W-1:0]  disp_m,
    input  logic [DIM_W-1:0]  disp_n,
    output logic              start_disp,
    output logic [ID_W-1:0]   matrix_id_sel,
    output logic              read_en,
    input  logic              meta_info_valid,
    input  logic              error_flag,
    input  logic [DATA_W-1:0] rd_data,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic [DATA_W-1:0] elem_data,
    output logic [DIM_W-1:0]  elem_row,
    output logic [DIM_W-1:0]  elem_col,
    output logic              elem_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_id;
    logic [DIM_W-1:0]  r_m;
    logic [DIM_W-1:0]  r_n;
    logic [TMO_W-1:0]  r_tmo;
    logic [DATA_W-1:0] r_elem_data;
    logic [DIM_W-1:0]  r_elem_row;
    logic [DIM_W-1:0]  r_elem_col;
    logic              r_elem_last;
    logic              r_err;

    logic              w_req_ok;
    logic              w_latch;
    logic              w_err_set;
    logic              w_tmo_inc;
    logic              w_rc_step;
    logic              w_capture;
    logic [DIM_W-1:0]  w_row;
    logic [DIM_W-1:0]  w_col;
    logic              w_last;

    assign w_req_ok = req_ok(disp_id, disp_m, disp_n);

    matrix_rc_counter u_rc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_latch),
        .i_step  (w_rc_step),
        .i_m     (r_m),
        .i_n     (r_n),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_err_set = 1'b0;
        w_tmo_inc = 1'b0;
        w_rc_step = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (disp_req) begin
                    if (w_req_ok) begin
                        w_latch = 1'b1;
                        w_next  = REQ;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            REQ:       w_next = WAIT_META;
            WAIT_META: begin
                // Acceptance beats rejection when storage raises both together.
                if (meta_info_valid) begin
                    w_next = READ;
                end else if (error_flag) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end else if (r_tmo == TMO_W'(META_TIMEOUT - 1)) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            READ:      w_next = CAPTURE;
            CAPTURE: begin
                w_capture = 1'b1;
                w_next    = PRESENT;
            end
            PRESENT: begin
                if (elem_ready) begin
                    if (r_elem_last) begin
                        w_next = DONE;
                    end else begin
                        w_rc_step = 1'b1;
                        w_next    = READ;
                    end
                end
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id <= '0;
            r_m  <= '0;
            r_n  <= '0;
        end else if (w_latch) begin
            r_id <= disp_id;
            r_m  <= disp_m;
            r_n  <= disp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == REQ)) begin
            r_tmo <= '0;
        end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Storage data is valid in CAPTURE, one cycle after the READ strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_elem_data <= '0;
            r_elem_row  <= '0;
            r_elem_col  <= '0;
            r_elem_last <= 1'b0;
        end else if (w_capture) begin
            r_elem_data <= rd_data;
            r_elem_row  <= w_row;
            r_elem_col  <= w_col;
            r_elem_last <= w_last;
        end
    end

    // Outputs are forced low while rst is held, even before the state register clears.
    assign start_disp    = !rst && (r_state == REQ);
    assign matrix_id_sel = start_disp ? r_id : '0;
    assign read_en       = !rst && (r_state == READ);
    assign elem_valid    = !rst && (r_state == PRESENT);
    assign elem_data     = rst ? '0 : r_elem_data;
    assign elem_row      = rst ? '0 : r_elem_row;
    assign elem_col      = rst ? '0 : r_elem_col;
    assign elem_last     = !rst && r_elem_last;
    assign busy          = !rst && (r_state != IDLE);
    assign done          = !rst && (r_state == DONE);
    assign err           = !rst && r_err;

endmodule

// File: tb/tb_matrix_display_reader.sv
// Randomized scoreboard bench for matrix_display_reader with a storage responder model.
module tb_matrix_display_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_req;
    logic [3:0] disp_id;
    logic [2:0] disp_m, disp_n;
    logic       start_disp;
    logic [3:0] matrix_id_sel;
    logic       read_en;
    logic       meta_info_valid;
    logic       error_flag;
    logic [7:0] rd_data;
    logic       elem_valid;
    logic       elem_ready;
    logic [7:0] elem_data;
    logic [2:0] elem_row, elem_col;
    logic       elem_last;
    logic       busy, done, err;

    matrix_display_reader dut (
        .clk(clk), .rst(rst), .disp_req(disp_req), .disp_id(disp_id),
        .disp_m(disp_m), .disp_n(disp_n), .start_disp(start_disp),
        .matrix_id_sel(matrix_id_sel), .read_en(read_en),
        .meta_info_valid(meta_info_valid), .error_flag(error_flag),
        .rd_data(rd_data), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
        .elem_last(elem_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] r;
        logic [2:0] c;
        logic       l;
    } elem_t;

    elem_t      exp_q[$];
    int         evt_q[$];          // 1 = done, 2 = err
    logic [7:0] mem [16][25];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int cur_id, m_mode, m_delay, rdy_mode, stall;
    int st_cnt, rd_cnt, t_req, first_hs, last_hs, exp_first, err_lat;
    bit lat_chk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Storage responder: meta handshake after start_disp, data one cycle after read_en.
    bit armed = 0, pend = 0;
    int wcnt = 0, ptr = 0, sid = 0;
    always @(negedge clk) begin
        if (rst) begin
            armed = 0; pend = 0;
            meta_info_valid = 0; error_flag = 0;
            rd_data = 8'($urandom);
        end else begin
            if (pend) begin
                rd_data = mem[sid][ptr];
                ptr++;
            end else begin
                rd_data = 8'($urandom);
            end
            pend = read_en;
            if (read_en) rd_cnt++;
            meta_info_valid = 0;
            error_flag = ($urandom_range(0, 7) == 0);
            if (armed) begin
                error_flag = 0;
                if (m_mode != 2 && wcnt == m_delay) begin
                    meta_info_valid = (m_mode == 0 || m_mode == 3);
                    error_flag      = (m_mode == 1 || m_mode == 3);
                    armed = 0;
                end else if (wcnt == 3) begin
                    armed = 0;
                end
                wcnt++;
            end
            if (start_disp) begin
                st_cnt++;
                chk("id_sel", matrix_id_sel, cur_id);
                sid = matrix_id_sel;
                ptr = 0; armed = 1; wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0: elem_ready = 1;
            1: elem_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (elem_valid && elem_row == 0 && elem_col == 1 && stall < 5) begin
                    elem_ready = 0; stall++;
                end else begin
                    elem_ready = 1;
                end
            end
            default: elem_ready = !(elem_valid && elem_row == 0 && elem_col == 2);
        endcase
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    elem_t prev, got;
    bit    prev_wait = 0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_wait = 0;
        end else begin
            if (elem_valid) begin
                if (prev_wait) begin
                    chk("hold_data", elem_data, prev.d);
                    chk("hold_row", elem_row, prev.r);
                    chk("hold_col", elem_col, prev.c);
                    chk("hold_last", elem_last, prev.l);
                end
                chk("read_en_in_present", read_en, 0);
                if (elem_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_elem", 1, 0);
                    end else begin
                        got = exp_q.pop_front();
                        chk("elem_data", elem_data, got.d);
                        chk("elem_row", elem_row, got.r);
                        chk("elem_col", elem_col, got.c);
                        chk("elem_last", elem_last, got.l);
                    end
                    if (lat_chk) begin
                        if (first_hs < 0) chk("first_latency", cyc - t_req, exp_first);
                        else chk("elem_gap", cyc - last_hs, 3);
                    end
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    prev_wait = 0;
                end else begin
                    prev_wait = 1;
                    prev.d = elem_data; prev.r = elem_row;
                    prev.c = elem_col;  prev.l = elem_last;
                end
            end else begin
                prev_wait = 0;
            end
            if (done) begin
                if (evt_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("event_done", evt_q.pop_front(), 1);
                if (lat_chk) chk("done_latency", cyc - last_hs, 1);
            end
            if (err) begin
                if (evt_q.size() == 0) chk("unexpected_err", 1, 0);
                else chk("event_err", evt_q.pop_front(), 2);
                chk("err_latency", cyc - t_req, err_lat);
            end
        end
    end

    task automatic do_txn(input int id, input int m, input int n, input int mode,
                          input int delay, input int rmode, input bit inject);
        bit    ok;
        bit    streams;
        int    k;
        elem_t e;
        ok = (id <= 9) && (m >= 1) && (m <= 5) && (n >= 1) && (n <= 5);
        streams = ok && (mode == 0 || mode == 3);
        @(negedge clk);
        cur_id = id; m_mode = mode; m_delay = delay; rdy_mode = rmode; stall = 0;
        st_cnt = 0; rd_cnt = 0; first_hs = -1;
        lat_chk = streams && (rmode == 0);
        exp_first = 5 + delay;
        err_lat = !ok ? 1 : (mode == 1 ? 3 + delay : 6);
        if (!ok || !streams) begin
            evt_q.push_back(2);
        end else begin
            for (int r = 0; r < m; r++)
                for (int c = 0; c < n; c++) begin
                    e.d = mem[id][r*n + c];
                    e.r = 3'(r);
                    e.c = 3'(c);
                    e.l = (r == m - 1) && (c == n - 1);
                    exp_q.push_back(e);
                end
            evt_q.push_back(1);
        end
        disp_req = 1; disp_id = 4'(id); disp_m = 3'(m); disp_n = 3'(n);
        t_req = cyc;
        @(negedge clk);
        disp_req = 0;
        #1 chk("busy_after_req", busy, ok);
        @(negedge clk);
        if (inject && ok) begin
            disp_req = 1;
            disp_id = 4'($urandom_range(0, 9));
            disp_m  = 3'($urandom_range(1, 5));
            disp_n  = 3'($urandom_range(1, 5));
            @(negedge clk);
            disp_req = 0;
        end
        k = 0;
        while ((exp_q.size() != 0 || evt_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            chk("txn_timeout", 1, 0);
            exp_q.delete(); evt_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("start_count", st_cnt, ok ? 1 : 0);
        chk("read_count", rd_cnt, streams ? m * n : 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, {start_disp, read_en, elem_valid, elem_last, busy, done, err}, 0);
        chk({nm, "_id_sel"}, matrix_id_sel, 0);
        chk({nm, "_data"}, elem_data, 0);
        chk({nm, "_rowcol"}, {elem_row, elem_col}, 0);
    endtask

    initial begin
        int k;
        elem_t e;
        rst = 1; disp_req = 0; disp_id = 0; disp_m = 0; disp_n = 0;
        rdy_mode = 0; m_mode = 0; m_delay = 0; cur_id = 0; t_req = 0;
        first_hs = -1; last_hs = 0; lat_chk = 0; err_lat = 0; stall = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 25; j++) mem[i][j] = 8'($urandom);
        repeat (3) @(negedge clk);
        #1 check_all_zero("in_reset");
        rst = 0;
        @(negedge clk);
        #1 check_all_zero("after_reset");

        for (int j = 0; j < 6; j++) mem[2][j] = 8'(j + 1);
        do_txn(2, 2, 3, 0, 0, 0, 0);
        do_txn(3, 2, 2, 0, 0, 2, 0);
        do_txn(4, 3, 3, 1, 0, 0, 0);
        do_txn(4, 3, 3, 2, 0, 0, 0);
        do_txn(1, 2, 2, 3, 1, 0, 0);
        do_txn(6, 1, 5, 0, 3, 0, 0);
        do_txn(10, 2, 2, 0, 0, 0, 0);
        do_txn(1, 0, 2, 0, 0, 0, 0);
        do_txn(1, 2, 6, 0, 0, 0, 0);
        do_txn(8, 2, 2, 0, 0, 0, 1);
        do_txn(9, 5, 5, 0, 0, 1, 0);

        // Reset while element (0,2) of a 3x3 matrix is being presented.
        @(negedge clk);
        cur_id = 5; m_mode = 0; m_delay = 0; rdy_mode = 3; lat_chk = 0;
        st_cnt = 0; rd_cnt = 0; first_hs = -1;
        for (int c = 0; c < 2; c++) begin
            e.d = mem[5][c]; e.r = 0; e.c = 3'(c); e.l = 0;
            exp_q.push_back(e);
        end
        disp_req = 1; disp_id = 5; disp_m = 3; disp_n = 3; t_req = cyc;
        @(negedge clk);
        disp_req = 0;
        k = 0;
        while (!(elem_valid && elem_col == 2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_third_elem", k < 200, 1);
        chk("two_elems_popped", exp_q.size(), 0);
        rst = 1;
        @(negedge clk);
        #1 check_all_zero("mid_stream_reset");
        rst = 0;
        exp_q.delete(); evt_q.delete();
        do_txn(7, 1, 1, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            do_txn($urandom_range(0, 11), $urandom_range(0, 6), $urandom_range(0, 6),
                   ($urandom_range(0, 5) < 3) ? 0 : $urandom_range(1, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
